result_streamer: RTL and testbench
==================================

// Module: result_streamer
// PURPOSE
//  Read-side counterpart of the product register file. Takes a snapshot of the packed
//  8 x 6-bit result matrix and streams it out one element per transfer, lowest index
//  first, over a valid/ready handshake.
//  Sits between the register file's packed contents bus and the downstream consumer
//  (display scanner / serial output).
// PARAMETERS
//  ELEM_W     6  width of one matrix element in bits
//  NUM_ELEMS  8  number of elements in the packed bus
//  IDX_W      3  element index width; must satisfy 2**IDX_W >= NUM_ELEMS
// PORTS
//  clk          in   1                  rising-edge clock
//  reset        in   1                  asynchronous, active-high reset
//  start        in   1                  request a stream of the current contents
//  contents_in  in   ELEM_W*NUM_ELEMS   packed matrix; element k at [k*ELEM_W +: ELEM_W]
//  elem_out     out  ELEM_W             element currently offered
//  elem_idx     out  IDX_W              index of elem_out
//  elem_valid   out  1                  elem_out/elem_idx are valid
//  elem_ready   in   1                  consumer accepts the element this cycle
//  busy         out  1                  stream in progress (SEND state)
//  done         out  1                  one-cycle pulse after the last element is accepted
// BEHAVIOUR
//  - All outputs are registered. On reset, all outputs and the snapshot register clear to 0
//    and the FSM enters IDLE.
//  - Reset asserted mid-stream aborts the stream immediately. No done pulse is produced.
//  - FSM states: IDLE -> SEND -> DONE -> IDLE.
//  - IDLE:
//    - elem_valid=0, busy=0, done=0.
//    - start=1 at a clock edge: snapshot <= contents_in, elem_idx <= 0,
//      elem_out <= contents_in[ELEM_W-1:0], elem_valid <= 1, busy <= 1; go to SEND.
//    - Net effect: the first element is offered the cycle after start.
//  - SEND: a transfer occurs on an edge where elem_valid && elem_ready.
//    - No transfer: elem_out, elem_idx and elem_valid hold exactly (no glitching, no skipping).
//    - Transfer with elem_idx < NUM_ELEMS-1: elem_idx+1, elem_out <= snapshot[(idx+1)*ELEM_W +: ELEM_W].
//      Back-to-back transfers occur with ready held high: 1 element/cycle.
//    - Transfer with elem_idx == NUM_ELEMS-1: elem_valid <= 0, busy <= 0, done <= 1; go to DONE.
//  - DONE: lasts exactly one cycle (done=1), then returns to IDLE and done returns to 0.
//    start is ignored while in DONE.
//  - start is ignored in SEND. Changes on contents_in after the snapshot do not affect
//    the stream in progress.
//  - start may be accepted on the first IDLE cycle after DONE, so done and the next stream
//    are separated by at least 1 idle cycle.
//  - Latency with ready held high:
//    - start edge N: element 0 valid after edge N.
//    - last element accepted at edge N+NUM_ELEMS.
//    - done high during the cycle after edge N+NUM_ELEMS.
//  - elem_ready is don't-care when elem_valid=0.
//  - elem_out is pure bit-slicing: no arithmetic, no sign extension.
// TESTING
//  T1 Basic stream:
//     element k = k+1, ready tied 1, pulse start
//     -> elem_out 1..8 on 8 consecutive cycles, elem_idx 0..7, done high exactly 1 cycle after.
//  T2 Backpressure:
//     ready low for 3 cycles while idx=2
//     -> elem_out=3, elem_idx=2 held stable for the whole stall; stream resumes with 4,
//        with no loss and no duplicate.
//  T3 Snapshot isolation:
//     change contents_in to all 6'h3F one cycle after start
//     -> streamed values remain 1..8.
//  T4 Start while busy:
//     assert start at idx=4 and during DONE
//     -> ignored; exactly 8 transfers, single done pulse, no restart.
//  T5 Reset mid-stream:
//     assert reset at idx=5
//     -> elem_valid, busy, done, elem_idx, elem_out all 0 immediately; no done pulse;
//        a fresh start then streams from idx 0.
//  T6 Edge values:
//     elements alternate 6'h00/6'h3F, ready toggling every cycle
//     -> exact values out, one transfer per ready-high cycle.

Source files
------------

// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - snapshots the packed result matrix and streams it one element per valid/ready transfer
module result_streamer #(
  parameter int ELEM_W    = 6,
  parameter int NUM_ELEMS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ELEM_W*NUM_ELEMS-1:0]   contents_in,
  output logic [ELEM_W-1:0]             elem_out,
  output logic [IDX_W-1:0]              elem_idx,
  output logic                          elem_valid,
  input  logic                          elem_ready,
  output logic                          busy,
  output logic                          done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [ELEM_W*NUM_ELEMS-1:0]   snap_q, snap_d;
  logic [ELEM_W-1:0]             elem_out_q, elem_out_d;
  logic [IDX_W-1:0]              elem_idx_q, elem_idx_d;
  logic                          elem_valid_q, elem_valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          xfer;
  logic [IDX_W-1:0]              next_idx;
  logic [ELEM_W-1:0]             next_elem;

  assign xfer = elem_valid_q && elem_ready;

  // Element following the one on offer, taken from the snapshot rather than the live bus.
  always_comb begin
    next_idx  = elem_idx_q + IDX_W'(1);
    next_elem = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      if (next_idx == IDX_W'(k)) begin
        next_elem = snap_q[k*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    elem_out_d   = elem_out_q;
    elem_idx_d   = elem_idx_q;
    elem_valid_d = elem_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d       = contents_in;
          elem_idx_d   = '0;
          elem_out_d   = contents_in[ELEM_W-1:0];
          elem_valid_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (elem_idx_q == LAST_IDX) begin
            elem_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end else begin
            elem_idx_d = next_idx;
            elem_out_d = next_elem;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        elem_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      elem_out_q   <= '0;
      elem_idx_q   <= '0;
      elem_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      elem_out_q   <= elem_out_d;
      elem_idx_q   <= elem_idx_d;
      elem_valid_q <= elem_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign elem_out   = elem_out_q;
  assign elem_idx   = elem_idx_q;
  assign elem_valid = elem_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - table-driven self-checking bench for result_streamer
module tb_result_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [47:0] contents_in;
  logic [5:0]  elem_out;
  logic [2:0]  elem_idx;
  logic        elem_valid;
  logic        elem_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  result_streamer #(.ELEM_W(6), .NUM_ELEMS(8), .IDX_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .contents_in(contents_in),
    .elem_out   (elem_out),
    .elem_idx   (elem_idx),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        ready;
    logic [47:0] contents;
    logic        ev;
    logic [2:0]  ei;
    logic [5:0]  eo;
    logic        eb;
    logic        ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic s, logic r, logic [47:0] c, logic ev, int ei, int eo,
                              logic eb, logic ed);
    vec_t v;
    v.start = s; v.ready = r; v.contents = c; v.ev = ev;
    v.ei = 3'(ei); v.eo = 6'(eo); v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endfunction

  function automatic logic [47:0] mk_seq();
    logic [47:0] c;
    for (int k = 0; k < 8; k++) c[k*6 +: 6] = 6'(k + 1);
    return c;
  endfunction

  function automatic logic [47:0] mk_alt();
    logic [47:0] c;
    for (int k = 0; k < 8; k++) c[k*6 +: 6] = (k % 2 == 1) ? 6'h3F : 6'h00;
    return c;
  endfunction

  // idx/out are only meaningful while elem_valid is high
  task automatic chk(string name, logic ev, int ei, int eo, logic eb, logic ed);
    logic ok;
    checks++;
    ok = (elem_valid === ev) && (busy === eb) && (done === ed) &&
         (!ev || (elem_idx === 3'(ei) && elem_out === 6'(eo)));
    if (!ok) begin
      errors++;
      $display("FAIL %s: got v=%b b=%b d=%b idx=%0d out=%h, want v=%b b=%b d=%b idx=%0d out=%h",
               name, elem_valid, busy, done, elem_idx, elem_out, ev, eb, ed, ei, eo);
    end
  endtask

  task automatic chk_zero(string name);
    checks++;
    if (elem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        elem_idx !== 3'd0 || elem_out !== 6'd0) begin
      errors++;
      $display("FAIL %s: got v=%b b=%b d=%b idx=%0d out=%h, want all zero",
               name, elem_valid, busy, done, elem_idx, elem_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] c1, c6, c3f;
    int cur;
    logic seen;
    c1  = mk_seq();
    c6  = mk_alt();
    c3f = {48{1'b1}};

    // T1 basic stream
    add(1, 1, c1, 1, 0, 1, 1, 0);
    for (int i = 1; i < 8; i++) add(0, 1, c1, 1, i, i + 1, 1, 0);
    add(0, 1, c1, 0, 0, 0, 0, 1);
    add(0, 1, c1, 0, 0, 0, 0, 0);
    // T2 backpressure at idx 2
    add(1, 0, c1, 1, 0, 1, 1, 0);
    add(0, 1, c1, 1, 1, 2, 1, 0);
    add(0, 1, c1, 1, 2, 3, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 0, c1, 1, 2, 3, 1, 0);
    for (int i = 3; i < 8; i++) add(0, 1, c1, 1, i, i + 1, 1, 0);
    add(0, 1, c1, 0, 0, 0, 0, 1);
    add(0, 1, c1, 0, 0, 0, 0, 0);
    // T3 snapshot isolation
    add(1, 1, c1, 1, 0, 1, 1, 0);
    for (int i = 1; i < 8; i++) add(0, 1, c3f, 1, i, i + 1, 1, 0);
    add(0, 1, c3f, 0, 0, 0, 0, 1);
    add(0, 1, c1, 0, 0, 0, 0, 0);
    // T4 start while busy and during DONE
    add(1, 1, c1, 1, 0, 1, 1, 0);
    for (int i = 1; i < 8; i++) add((i == 5 || i == 6), 1, c1, 1, i, i + 1, 1, 0);
    add(0, 1, c1, 0, 0, 0, 0, 1);
    add(1, 1, c1, 0, 0, 0, 0, 0);
    add(0, 1, c1, 0, 0, 0, 0, 0);
    add(0, 1, c1, 0, 0, 0, 0, 0);
    // T6 alternating edge values, ready toggling
    add(1, 0, c6, 1, 0, 0, 1, 0);
    cur = 0;
    for (int t = 0; t < 32; t++) begin
      logic r;
      r = (t % 2 == 0);
      if (r && cur == 7) begin
        add(0, 1, c6, 0, 0, 0, 0, 1);
        break;
      end
      if (r) cur++;
      add(0, r, c6, 1, cur, (cur % 2 == 1) ? 6'h3F : 6'h00, 1, 0);
    end
    add(0, 0, c6, 0, 0, 0, 0, 0);

    // Reset state
    reset = 1'b1; start = 1'b0; elem_ready = 1'b0; contents_in = c1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_zero("after_reset_idle");

    for (int j = 0; j < vecs.size(); j++) begin
      start       = vecs[j].start;
      elem_ready  = vecs[j].ready;
      contents_in = vecs[j].contents;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", j), vecs[j].ev, vecs[j].ei, vecs[j].eo, vecs[j].eb, vecs[j].ed);
    end

    // T5 reset mid-stream
    start = 1'b1; elem_ready = 1'b1; contents_in = c1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_first", 1, 0, 1, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_idx5", 1, 5, 6, 1, 0);
    reset = 1'b1;
    #1;
    chk_zero("t5_reset_immediate");
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("t5_reset_edge");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || elem_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL t5_no_done_after_abort: got activity=1, want 0");
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_restart_idx0", 1, 0, 1, 1, 0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t5_restart_idx%0d", i), 1, i, i + 1, 1, 0);
    end
    @(posedge clk); #1;
    chk("t5_restart_done", 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("t5_restart_idle", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
